// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper
//
// Keeps the score of a two-player match. Each player's point line is
// edge-detected. Accepted points bump the score, emit a one-cycle point_event
// and freeze play for HOLD_CYCLES clocks. The match ends when a score reaches
// WIN_SCORE. While the match is over, the winner's display blinks with a
// half-period of BLINK_CYCLES clocks.
//
// Parameters
//   WIN_SCORE    : winning score, 1..15
//   HOLD_CYCLES  : freeze time after each accepted point, in clk cycles (>=1)
//   BLINK_CYCLES : half-period of the winner blink, in clk cycles (>=1)
//
// Ports
//   clk          in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   clear        in   level; clears the match and starts play
//   p0_point     in   level; player 0 scored
//   p1_point     in   level; player 1 scored
//   score0       out  [3:0] player 0 score
//   score1       out  [3:0] player 1 score
//   point_event  out  one-cycle pulse per accepted point (registered)
//   restart      out  level; match over (registered)
//   winner       out  [1:0] 01 = p0, 10 = p1, 11 = tie, 00 = none (registered)
//   blink        out  winner blink phase, 0 outside OVER (registered)
//   hex0         out  [6:0] active-low 7-segment code of score0, bit0 = seg a
//   hex2         out  [6:0] active-low 7-segment code of score1, bit0 = seg a
// -----------------------------------------------------------------------------
module score_keeper #(
  parameter int WIN_SCORE    = 7,
  parameter int HOLD_CYCLES  = 25_000_000,
  parameter int BLINK_CYCLES = 12_500_000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       clear,
  input  logic       p0_point,
  input  logic       p1_point,
  output logic [3:0] score0,
  output logic [3:0] score1,
  output logic       point_event,
  output logic       restart,
  output logic [1:0] winner,
  output logic       blink,
  output logic [6:0] hex0,
  output logic [6:0] hex2
);

  // Counter widths: wide enough to hold the reload value (N-1), never zero.
  localparam int HOLD_W  = (HOLD_CYCLES  > 1) ? $clog2(HOLD_CYCLES)  : 1;
  localparam int BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [3:0]         WIN        = 4'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HOLD = 2'd2,
    S_OVER = 2'd3
  } state_e;

  state_e             state_q;
  logic               p0_prev_q;
  logic               p1_prev_q;
  logic [3:0]         score0_q;
  logic [3:0]         score1_q;
  logic               point_event_q;
  logic               restart_q;
  logic [1:0]         winner_q;
  logic               blink_q;
  logic [HOLD_W-1:0]  hold_cnt_q;
  logic [BLINK_W-1:0] blink_cnt_q;

  // Candidate next scores, used only when a point is accepted in PLAY.
  logic       rise0;
  logic       rise1;
  logic       point_hit;
  logic [3:0] score0_d;
  logic [3:0] score1_d;
  logic       win0_d;
  logic       win1_d;

  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    rise0     = p0_point & ~p0_prev_q;
    rise1     = p1_point & ~p1_prev_q;
    point_hit = rise0 | rise1;
    score0_d  = score0_q;
    score1_d  = score1_q;
    // Saturate at WIN so the 4-bit counters can never wrap.
    if (rise0 && (score0_q < WIN)) score0_d = score0_q + 4'd1;
    if (rise1 && (score1_q < WIN)) score1_d = score1_q + 4'd1;
    win0_d = (score0_d == WIN);
    win1_d = (score1_d == WIN);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge regardless of order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      p0_prev_q     <= 1'b0;
      p1_prev_q     <= 1'b0;
      score0_q      <= 4'd0;
      score1_q      <= 4'd0;
      point_event_q <= 1'b0;
      restart_q     <= 1'b0;
      winner_q      <= 2'b00;
      blink_q       <= 1'b0;
      hold_cnt_q    <= '0;
      blink_cnt_q   <= '0;
    end else begin
      // Edge registers sample every cycle, in every state, so a level held
      // through HOLD or a clear is never seen as a fresh rise afterwards.
      p0_prev_q     <= p0_point;
      p1_prev_q     <= p1_point;
      point_event_q <= 1'b0;

      if (clear) begin
        // Clear wins over any point arriving on the same edge.
        state_q     <= S_PLAY;
        score0_q    <= 4'd0;
        score1_q    <= 4'd0;
        restart_q   <= 1'b0;
        winner_q    <= 2'b00;
        blink_q     <= 1'b0;
        hold_cnt_q  <= '0;
        blink_cnt_q <= '0;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            // Waiting for clear; points are ignored.
          end

          S_PLAY: begin
            if (point_hit) begin
              score0_q      <= score0_d;
              score1_q      <= score1_d;
              point_event_q <= 1'b1;
              if (win0_d || win1_d) begin
                state_q     <= S_OVER;
                restart_q   <= 1'b1;
                winner_q    <= {win1_d, win0_d};
                blink_q     <= 1'b1;
                blink_cnt_q <= BLINK_LOAD;
              end else begin
                state_q    <= S_HOLD;
                hold_cnt_q <= HOLD_LOAD;
              end
            end
          end

          S_HOLD: begin
            // Loaded with N-1 and left on the zero cycle: N cycles in HOLD.
            if (hold_cnt_q == '0) begin
              state_q <= S_PLAY;
            end else begin
              hold_cnt_q <= hold_cnt_q - 1'b1;
            end
          end

          S_OVER: begin
            // Scores and winner stay frozen until clear or reset.
            if (blink_cnt_q == '0) begin
              blink_q     <= ~blink_q;
              blink_cnt_q <= BLINK_LOAD;
            end else begin
              blink_cnt_q <= blink_cnt_q - 1'b1;
            end
          end

          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Active-low seven-segment code, bit0 = segment a, bit6 = segment g.
  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] seg;
    unique case (v)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

  // The winner's digit goes dark during the off phase of the blink; a tie
  // blanks both digits together.
  logic blank_phase;
  assign blank_phase = (state_q == S_OVER) && !blink_q;

  assign hex0 = (blank_phase && winner_q[0]) ? 7'b1111111 : hex_seg(score0_q);
  assign hex2 = (blank_phase && winner_q[1]) ? 7'b1111111 : hex_seg(score1_q);

  assign score0      = score0_q;
  assign score1      = score1_q;
  assign point_event = point_event_q;
  assign restart     = restart_q;
  assign winner      = winner_q;
  assign blink       = blink_q;

endmodule
